// File: rtl/pipeline_stage_sequencer_pkg.sv
// Shared encodings for the pipeline stage sequencer: FSM state codes,
// operating-mode values and a small state-classification helper.
package pipeline_stage_sequencer_pkg;

    localparam logic [2:0] STAGE_SEQ_STATE_INIT     = 3'd0;
    localparam logic [2:0] STAGE_SEQ_STATE_RUN_SEQ  = 3'd1;
    localparam logic [2:0] STAGE_SEQ_STATE_RUN_PIPE = 3'd2;
    localparam logic [2:0] STAGE_SEQ_STATE_DRAIN    = 3'd3;
    localparam logic [2:0] STAGE_SEQ_STATE_HALTED   = 3'd4;

    localparam logic STAGE_SEQ_MODE_SEQUENTIAL = 1'b0;
    localparam logic STAGE_SEQ_MODE_PIPELINED  = 1'b1;

    // True in the states where the core is doing work (performance-counted).
    function automatic logic stage_seq_is_running(input logic [2:0] state);
        return (state == STAGE_SEQ_STATE_RUN_SEQ) ||
               (state == STAGE_SEQ_STATE_RUN_PIPE) ||
               (state == STAGE_SEQ_STATE_DRAIN);
    endfunction

endpackage

// File: rtl/pipeline_stage_sequencer_phase_counter.sv
// stage_phase_counter: modulo-COUNT phase counter used by the sequential
// (multi-cycle) mode. Synchronous clear has priority over enable; o_last
// flags the final phase, i.e. the instruction boundary.
module stage_phase_counter #(
    parameter int COUNT = 5,
    parameter int W     = $clog2(COUNT)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_clear,
    input  logic         i_en,
    output logic [W-1:0] o_phase,
    output logic         o_last
);

    logic [W-1:0] r_phase;
    logic         w_last;

    assign w_last  = (r_phase == W'(COUNT - 1));
    assign o_phase = r_phase;
    assign o_last  = w_last;

    // Advance the phase and wrap at the boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_phase <= '0;
        else if (i_clear)
            r_phase <= '0;
        else if (i_en)
            r_phase <= w_last ? '0 : r_phase + 1'b1;
    end

endmodule

// File: rtl/pipeline_stage_sequencer.sv
// pipeline_stage_sequencer: drives PC / pipeline-register write enables,
// bubble clears and RAM / register-file write strobes, in either
// multi-cycle sequential mode or fully pipelined mode.
// Optional performance counters are built when STAGE_SEQ_PERF_EN is defined;
// otherwise cycle_count / retire_count are tied to zero.
//
// state    | meaning
// INIT     | after reset, choose mode or go straight to HALTED
// RUN_SEQ  | one stage per cycle, phase counter selects the stage
// RUN_PIPE | all stages active, stall / flush / halt handled
// DRAIN    | no new fetches, wait for in-flight instructions to retire
// HALTED   | stopped, all strobes low
module pipeline_stage_sequencer #(
    parameter int STAGE_COUNT = 5,
    parameter int RAM_STAGE   = 3,
    parameter int FLUSH_DEPTH = 2,
    parameter int PERF_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   mode_pipelined,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   halt,
    output logic                   pc_wren,
    output logic [STAGE_COUNT-2:0] pipe_wren,
    output logic [STAGE_COUNT-2:0] pipe_clear,
    output logic                   ram_wren,
    output logic                   reg_wren,
    output logic [STAGE_COUNT-1:0] stage_valid,
    output logic                   halted,
    output logic [PERF_WIDTH-1:0]  cycle_count,
    output logic [PERF_WIDTH-1:0]  retire_count
);

    import pipeline_stage_sequencer_pkg::*;

    localparam int NREG    = STAGE_COUNT - 1;
    localparam int PHASE_W = $clog2(STAGE_COUNT);
    localparam logic [NREG-1:0] FLUSH_MASK = NREG'((1 << FLUSH_DEPTH) - 1);

    logic [2:0]             r_state;
    logic [2:0]             w_next_state;
    logic                   r_halt_pend;
    logic [STAGE_COUNT-1:1] r_valid;
    logic [STAGE_COUNT-1:0] w_valid;
    logic [PHASE_W-1:0]     w_phase;
    logic                   w_phase_last;
    logic                   w_run_seq;
    logic                   w_run_pipe;
    logic                   w_drain;

    assign w_run_seq  = (r_state == STAGE_SEQ_STATE_RUN_SEQ);
    assign w_run_pipe = (r_state == STAGE_SEQ_STATE_RUN_PIPE);
    assign w_drain    = (r_state == STAGE_SEQ_STATE_DRAIN);

    stage_phase_counter #(
        .COUNT (STAGE_COUNT),
        .W     (PHASE_W)
    ) u_phase (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (!w_run_seq),
        .i_en    (w_run_seq),
        .o_phase (w_phase),
        .o_last  (w_phase_last)
    );

    // Strobes, clears and next state from registered state plus same-cycle requests.
    always_comb begin
        w_next_state = r_state;
        w_valid      = '0;
        pc_wren      = 1'b0;
        pipe_wren    = '0;
        pipe_clear   = '0;
        ram_wren     = 1'b0;
        reg_wren     = 1'b0;
        case (r_state)
            STAGE_SEQ_STATE_INIT: begin
                if (halt)
                    w_next_state = STAGE_SEQ_STATE_HALTED;
                else if (mode_pipelined == STAGE_SEQ_MODE_PIPELINED)
                    w_next_state = STAGE_SEQ_STATE_RUN_PIPE;
                else
                    w_next_state = STAGE_SEQ_STATE_RUN_SEQ;
            end
            STAGE_SEQ_STATE_RUN_SEQ: begin
                w_valid  = STAGE_COUNT'(1) << w_phase;
                ram_wren = (w_phase == PHASE_W'(RAM_STAGE));
                if (w_phase_last) begin
                    pc_wren  = 1'b1;
                    reg_wren = 1'b1;
                    if (halt || r_halt_pend)
                        w_next_state = STAGE_SEQ_STATE_HALTED;
                end else begin
                    pipe_wren = NREG'(1) << w_phase;
                end
            end
            STAGE_SEQ_STATE_RUN_PIPE: begin
                w_valid   = {r_valid, 1'b1};
                pc_wren   = 1'b1;
                pipe_wren = '1;
                if (flush) begin
                    pipe_clear = FLUSH_MASK;
                end else if (stall) begin
                    pc_wren       = 1'b0;
                    pipe_wren[0]  = 1'b0;
                    pipe_clear[1] = 1'b1;
                end
                if (halt) begin
                    pc_wren       = 1'b0;
                    pipe_clear[0] = 1'b1;
                    w_next_state  = STAGE_SEQ_STATE_DRAIN;
                end
                ram_wren = w_valid[RAM_STAGE];
                reg_wren = w_valid[STAGE_COUNT-1];
            end
            STAGE_SEQ_STATE_DRAIN: begin
                w_valid    = {r_valid, 1'b0};
                pipe_wren  = '1;
                pipe_clear = flush ? (FLUSH_MASK | NREG'(1)) : NREG'(1);
                ram_wren   = w_valid[RAM_STAGE];
                reg_wren   = w_valid[STAGE_COUNT-1];
                if (r_valid == '0)
                    w_next_state = STAGE_SEQ_STATE_HALTED;
            end
            STAGE_SEQ_STATE_HALTED: begin
                if (!halt)
                    w_next_state = (mode_pipelined == STAGE_SEQ_MODE_PIPELINED) ?
                                   STAGE_SEQ_STATE_RUN_PIPE : STAGE_SEQ_STATE_RUN_SEQ;
            end
            default: w_next_state = STAGE_SEQ_STATE_INIT;
        endcase
    end

    assign stage_valid = w_valid;
    assign halted      = (r_state == STAGE_SEQ_STATE_HALTED);

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= STAGE_SEQ_STATE_INIT;
        else
            r_state <= w_next_state;
    end

    // Remember a sequential-mode halt until the instruction boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_halt_pend <= 1'b0;
        else if (w_run_seq && !w_phase_last)
            r_halt_pend <= r_halt_pend | halt;
        else
            r_halt_pend <= 1'b0;
    end

    // Valid bits follow the pipeline registers; bubbles load zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (w_run_pipe || w_drain) begin
            for (int k = 0; k < NREG; k++) begin
                if (pipe_wren[k])
                    r_valid[k+1] <= pipe_clear[k] ? 1'b0 : w_valid[k];
            end
        end else begin
            r_valid <= '0;
        end
    end

`ifdef STAGE_SEQ_PERF_EN
    logic [PERF_WIDTH-1:0] r_cycle_count;
    logic [PERF_WIDTH-1:0] r_retire_count;

    // Free-running work and retirement counters, wrapping naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle_count  <= '0;
            r_retire_count <= '0;
        end else begin
            if (stage_seq_is_running(r_state))
                r_cycle_count <= r_cycle_count + 1'b1;
            if (reg_wren)
                r_retire_count <= r_retire_count + 1'b1;
        end
    end

    assign cycle_count  = r_cycle_count;
    assign retire_count = r_retire_count;
`else
    assign cycle_count  = '0;
    assign retire_count = '0;
`endif

endmodule
